cam_pixel_capture: RTL and testbench

- Writer side of the frame-buffer pixel interface.
- Receives the camera's byte-serial RGB565 stream (DATA/HREF/VSYNC) and packs each pixel to RGB332.
- Writes each pixel to the 176x144 frame buffer with a linear address and write enable.
- Pixel layout matches what the colour-detection reader consumes: R in [7:5], G in [4:2], B in [1:0].

---
 rtl/cam_pixel_capture_if.sv | 25 ++
 rtl/cam_pixel_capture.sv | 133 +++++++++++++
 tb/tb_cam_pixel_capture.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cam_pixel_capture_if.sv
// Pixel-capture bus: camera byte stream in, frame-buffer writes out.
// Ports: CAM_DATA/CAM_HREF/CAM_VSYNC (camera), PIXEL_OUT/WRITE_ADDRESS/W_EN/FRAME_DONE (memory).
interface cam_pixel_capture_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        CAM_DATA;
    logic              CAM_HREF;
    logic              CAM_VSYNC;
    logic [7:0]        PIXEL_OUT;
    logic [ADDR_W-1:0] WRITE_ADDRESS;
    logic              W_EN;
    logic              FRAME_DONE;

    // master: camera source / memory sink side
    modport master (
        output CAM_DATA, CAM_HREF, CAM_VSYNC,
        input  PIXEL_OUT, WRITE_ADDRESS, W_EN, FRAME_DONE
    );

    // slave: the capture block itself
    modport slave (
        input  CAM_DATA, CAM_HREF, CAM_VSYNC,
        output PIXEL_OUT, WRITE_ADDRESS, W_EN, FRAME_DONE
    );
endinterface

// File: rtl/cam_pixel_capture.sv
// Packs the camera RGB565 byte stream into RGB332 and writes it to a frame buffer.
// Ports: CLK, RESET_N (sync, active-low), bus (slave side of cam_pixel_capture_if).
module cam_pixel_capture #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144,
    parameter int ADDR_W = 15
) (
    input logic CLK,
    input logic RESET_N,
    cam_pixel_capture_if.slave bus
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT);

    typedef enum logic [1:0] {
        SYNC,
        BLANK,
        HI,
        LO
    } state_t;

    state_t            state, state_n;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [7:0]        hi_byte, hi_byte_n;
    logic              href_q;
    logic              vsync_q;
    logic [7:0]        pixel, pixel_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              w_en, w_en_n;
    logic              frame_done, frame_done_n;

    logic vs_rise;
    logic vs_fall;
    logic href_fall;

    assign vs_rise   = bus.CAM_VSYNC & ~vsync_q;
    assign vs_fall   = ~bus.CAM_VSYNC & vsync_q;
    assign href_fall = ~bus.CAM_HREF & href_q;

    assign bus.PIXEL_OUT     = pixel;
    assign bus.WRITE_ADDRESS = addr;
    assign bus.W_EN          = w_en;
    assign bus.FRAME_DONE    = frame_done;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= SYNC;
            x          <= '0;
            y          <= '0;
            hi_byte    <= '0;
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            pixel      <= '0;
            addr       <= '0;
            w_en       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            hi_byte    <= hi_byte_n;
            href_q     <= bus.CAM_HREF;
            vsync_q    <= bus.CAM_VSYNC;
            pixel      <= pixel_n;
            addr       <= addr_n;
            w_en       <= w_en_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        x_n          = x;
        y_n          = y;
        hi_byte_n    = hi_byte;
        pixel_n      = pixel;
        addr_n       = addr;
        w_en_n       = 1'b0;
        frame_done_n = 1'b0;

        unique case (state)
            SYNC: begin
                // wait for a clean frame start; partial frames are skipped
                if (vs_rise) begin
                    state_n = BLANK;
                end
            end
            BLANK: begin
                if (vs_fall) begin
                    x_n     = '0;
                    y_n     = '0;
                    state_n = HI;
                end
            end
            HI, LO: begin
                if (vs_rise) begin
                    // end of frame wins over any byte or line edge
                    frame_done_n = 1'b1;
                    state_n      = BLANK;
                end else if (href_fall) begin
                    // unpaired high byte is dropped; empty lines keep Y
                    state_n = HI;
                    if (x != '0) begin
                        if (y != Y_MAX) begin
                            y_n = y + 1'b1;
                        end
                        x_n = '0;
                    end
                end else if (bus.CAM_HREF) begin
                    if (state == HI) begin
                        hi_byte_n = bus.CAM_DATA;
                        state_n   = LO;
                    end else begin
                        if (x < X_MAX && y < Y_MAX) begin
                            w_en_n  = 1'b1;
                            pixel_n = {hi_byte[7:5], hi_byte[2:0],
                                       bus.CAM_DATA[4:3]};
                            addr_n  = ADDR_W'(int'(y) * WIDTH + int'(x));
                        end
                        if (x != X_MAX) begin
                            x_n = x + 1'b1;
                        end
                        state_n = HI;
                    end
                end
            end
            default: state_n = SYNC;
        endcase
    end
endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture: directed camera frames, queued writes.
// Ports: none (top-level bench).
module tb_cam_pixel_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cam_pixel_capture_if #(.ADDR_W(15)) bus ();

    cam_pixel_capture #(
        .WIDTH (176),
        .HEIGHT(144),
        .ADDR_W(15)
    ) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .bus    (bus)
    );

    typedef struct {
        int addr;
        int pix;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   neg_cnt  = 0;
    int   we_cnt   = 0;
    int   fd_cnt   = 0;
    int   fd_cyc   = 0;
    int   last_we  = 0;
    logic fd_prev  = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // monitor: compare every write against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (bus.W_EN) begin
                we_cnt++;
                last_we = neg_cnt;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wen: addr %0d pix %0h",
                             bus.WRITE_ADDRESS, bus.PIXEL_OUT);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(bus.WRITE_ADDRESS), e.addr);
                    chk("wr_pix", int'(bus.PIXEL_OUT), e.pix);
                    chk("wr_cycle", neg_cnt, e.cyc);
                end
            end
            if (bus.FRAME_DONE) begin
                fd_cnt++;
                fd_cyc = neg_cnt;
                if (fd_prev) chk("fd_width", 2, 1);
            end
            fd_prev = bus.FRAME_DONE;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] p332(input logic [7:0] h, input logic [7:0] l);
        return {h[7:5], h[2:0], l[4:3]};
    endfunction

    task automatic send_px(input logic [7:0] h, input logic [7:0] l,
                           input bit ex, input int a, input logic [7:0] p);
        exp_t e;
        bus.CAM_DATA = h;
        bus.CAM_HREF = 1'b1;
        tick();
        bus.CAM_DATA = l;
        tick();
        if (ex) begin
            e.addr = a;
            e.pix  = int'(p);
            e.cyc  = neg_cnt + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic end_line();
        bus.CAM_HREF = 1'b0;
        bus.CAM_DATA = 8'h00;
        tick();
        tick();
    endtask

    task automatic frame_start();
        bus.CAM_HREF  = 1'b0;
        bus.CAM_VSYNC = 1'b1;
        tick();
        tick();
        bus.CAM_VSYNC = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame_end(input int fd_req);
        bus.CAM_HREF  = 1'b0;
        bus.CAM_VSYNC = 1'b1;
        tick();
        tick();
        tick();
        chk("frame_done_count", fd_cnt, fd_req);
    endtask

    task automatic line(input int n, input int yv);
        logic [7:0] h;
        logic [7:0] l;
        for (int i = 0; i < n; i++) begin
            h = 8'(i * 7 + yv);
            l = 8'(i * 13 + yv * 3);
            send_px(h, l, (i < 176) && (yv < 144), yv * 176 + i, p332(h, l));
        end
        end_line();
    endtask

    initial begin
        bus.CAM_DATA  = 8'h00;
        bus.CAM_HREF  = 1'b0;
        bus.CAM_VSYNC = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_pixel", int'(bus.PIXEL_OUT), 0);
        chk("rst_addr", int'(bus.WRITE_ADDRESS), 0);
        chk("rst_wen", int'(bus.W_EN), 0);
        chk("rst_fd", int'(bus.FRAME_DONE), 0);
        rst_n = 1'b1;
        tick();

        // data before the first VSYNC must be ignored
        for (int i = 0; i < 4; i++) send_px(8'hA5, 8'h5A, 1'b0, 0, 8'h00);
        end_line();
        for (int i = 0; i < 2; i++) send_px(8'h3C, 8'hC3, 1'b0, 0, 8'h00);
        end_line();

        // frame 1: colour vectors, empty line, second line
        frame_start();
        send_px(8'hF8, 8'h00, 1'b1, 0, 8'hE0);
        send_px(8'h07, 8'hE0, 1'b1, 1, 8'h1C);
        send_px(8'h00, 8'h1F, 1'b1, 2, 8'h03);
        send_px(8'hFF, 8'hFF, 1'b1, 3, 8'hFF);
        end_line();
        bus.CAM_DATA = 8'h55;
        bus.CAM_HREF = 1'b1;
        tick();
        end_line();
        line(4, 1);
        frame_end(1);

        // frame 2: over-long line, then odd byte count
        frame_start();
        line(180, 0);
        line(2, 1);
        send_px(8'h12, 8'h34, 1'b1, 352, p332(8'h12, 8'h34));
        bus.CAM_DATA = 8'hE7;
        bus.CAM_HREF = 1'b1;
        tick();
        end_line();
        send_px(8'h9A, 8'h18, 1'b1, 528, p332(8'h9A, 8'h18));
        end_line();
        frame_end(2);

        // frame 3: taller than HEIGHT
        frame_start();
        for (int r = 0; r < 150; r++) line(2, r);
        frame_end(3);
        chk("fd_after_last_we", int'(fd_cyc >= last_we), 1);
        chk("last_we_addr", int'(bus.WRITE_ADDRESS), 25169);

        // reset between high and low byte
        frame_start();
        bus.CAM_DATA = 8'hAB;
        bus.CAM_HREF = 1'b1;
        tick();
        rst_n = 1'b0;
        bus.CAM_DATA = 8'hCD;
        tick();
        chk("mid_rst_wen", int'(bus.W_EN), 0);
        chk("mid_rst_pixel", int'(bus.PIXEL_OUT), 0);
        chk("mid_rst_addr", int'(bus.WRITE_ADDRESS), 0);
        chk("mid_rst_fd", int'(bus.FRAME_DONE), 0);
        rst_n = 1'b1;
        send_px(8'h11, 8'h22, 1'b0, 0, 8'h00);
        send_px(8'h33, 8'h44, 1'b0, 0, 8'h00);
        end_line();
        frame_start();
        send_px(8'hF8, 8'h00, 1'b1, 0, 8'hE0);
        end_line();
        frame_end(4);

        repeat (4) tick();
        chk("queue_empty", exp_q.size(), 0);
        chk("total_writes", we_cnt, 8 + 180 + 288 + 1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
